// File: rtl/crc_pkg.sv
// Shared types and helpers for the replay-buffer CRC engine.
// Used by crc_unroll and crc_engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  // Widest CRC the generic step function handles.
  localparam int unsigned CRC_MAX_W = 64;

  function automatic int unsigned calc_nstep(input int unsigned data_w,
                                             input int unsigned crc_w,
                                             input int unsigned bpc);
    return (data_w - crc_w) / bpc;
  endfunction

  // One MSB-first, non-reflected bit update of a w-bit CRC held in the low bits.
  function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] crc,
                                                    input logic                 b,
                                                    input logic [CRC_MAX_W-1:0] poly,
                                                    input int unsigned          w);
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] nxt;
    logic                 fb;
    mask = (w >= CRC_MAX_W) ? '1 : ((CRC_MAX_W'(1) << w) - CRC_MAX_W'(1));
    fb   = crc[w-1] ^ b;
    nxt  = (crc << 1) & mask;
    if (fb) nxt = nxt ^ (poly & mask);
    return nxt;
  endfunction

endpackage

// File: rtl/crc_unroll.sv
// Combinational BITS_PER_CYCLE-bit CRC update; data_in is consumed MSB first.
module crc_unroll
  import crc_pkg::*;
#(
  parameter int unsigned       CRC_W          = 16,
  parameter logic [CRC_W-1:0]  POLY           = 16'h1021,
  parameter int unsigned       BITS_PER_CYCLE = 8
) (
  input  logic [CRC_W-1:0]          crc_in,
  input  logic [BITS_PER_CYCLE-1:0] data_in,
  output logic [CRC_W-1:0]          crc_out
);

  always_comb begin
    logic [CRC_W-1:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      c = CRC_W'(crc_step(CRC_MAX_W'(c), data_in[BITS_PER_CYCLE-1-i],
                          CRC_MAX_W'(POLY), CRC_W));
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_engine.sv
// Multi-cycle CRC engine: fills (or, with CRC_CHECK_EN, verifies) the low CRC_W
// bits of a packet, consuming BITS_PER_CYCLE payload bits per clock.
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W         = 128,
  parameter int unsigned      CRC_W          = 16,
  parameter logic [CRC_W-1:0] POLY           = 16'h1021,
  parameter logic [CRC_W-1:0] INIT           = 16'hFFFF,
  parameter int unsigned      BITS_PER_CYCLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CRC_W-1:0]  out_crc,
`ifdef CRC_CHECK_EN
  input  logic              in_check,
  output logic              crc_err,
`endif
  output logic              busy
);

  localparam int unsigned PAY_W = DATA_W - CRC_W;
  localparam int unsigned NSTEP = calc_nstep(DATA_W, CRC_W, BITS_PER_CYCLE);
  localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (!(CRC_W < DATA_W) || ((DATA_W - CRC_W) % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
    $error("crc_engine: need CRC_W < DATA_W and payload width divisible by BITS_PER_CYCLE");
  end

  state_t             state, state_nx;
  logic [PAY_W-1:0]   pay;
  logic [CRC_W-1:0]   crc, crc_nx;
  logic [CNT_W-1:0]   cnt;

  crc_unroll #(
    .CRC_W          (CRC_W),
    .POLY           (POLY),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_unroll (
    .crc_in  (crc),
    .data_in (pay[PAY_W-1 -: BITS_PER_CYCLE]),
    .crc_out (crc_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (cnt == CNT_W'(NSTEP - 1)) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The payload register rotates rather than shifts, so after NSTEP steps it
  // holds the original payload again and no second copy is needed for output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pay <= '0;
      crc <= INIT;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      pay <= in_data[DATA_W-1:CRC_W];
      crc <= INIT;
      cnt <= '0;
    end else if (state == CALC) begin
      pay <= (pay << BITS_PER_CYCLE) | (pay >> (PAY_W - BITS_PER_CYCLE));
      crc <= crc_nx;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_crc   = crc;

`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0] field;
  logic             chk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field <= '0;
      chk   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      field <= in_data[CRC_W-1:0];
      chk   <= in_check;
    end
  end

  assign out_data = (state == HOLD) ? {pay, (chk ? field : crc)} : '0;
  assign crc_err  = (state == HOLD) && chk && (crc != field);
`else
  logic unused_field;
  assign unused_field = ^in_data[CRC_W-1:0];
  assign out_data     = (state == HOLD) ? {pay, crc} : '0;
`endif

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine at DATA_W=88 (BITS_PER_CYCLE 8 and 1 instances).
module tb_crc_engine;

  localparam int unsigned DW    = 88;
  localparam int unsigned CW    = 16;
  localparam int unsigned PW    = 72;
  localparam int unsigned NSTEP = 9;
  localparam logic [PW-1:0] V1  = 72'h313233343536373839;
  localparam logic [CW-1:0] C1  = 16'h29B1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] out_crc;
  logic          in_valid1 = 1'b0, in_ready1, out_valid1, busy1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] out_crc1;
`ifdef CRC_CHECK_EN
  logic in_check = 1'b0, crc_err, crc_err1;
`endif

  crc_engine #(.DATA_W(DW), .CRC_W(CW), .POLY(16'h1021), .INIT(16'hFFFF),
               .BITS_PER_CYCLE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_crc(out_crc),
`ifdef CRC_CHECK_EN
    .in_check(in_check), .crc_err(crc_err),
`endif
    .busy(busy));

  crc_engine #(.DATA_W(DW), .CRC_W(CW), .POLY(16'h1021), .INIT(16'hFFFF),
               .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(1'b1),
    .out_data(out_data1), .out_crc(out_crc1),
`ifdef CRC_CHECK_EN
    .in_check(1'b0), .crc_err(crc_err1),
`endif
    .busy(busy1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Byte-wise CCITT reference, structured differently from the engine's bit chain.
  function automatic logic [CW-1:0] ref_crc(input logic [PW-1:0] p);
    logic [CW-1:0] c;
    c = 16'hFFFF;
    for (int j = 8; j >= 0; j--) begin
      c = c ^ {p[j*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] crc;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   hs_cyc = 0;

  task automatic send(input logic [PW-1:0] p, input logic [CW-1:0] f, input logic chk,
                      input logic [CW-1:0] exp_crc, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {p, f};
`ifdef CRC_CHECK_EN
    in_check = chk;
`endif
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    e.data   = chk ? {p, f} : {p, exp_crc};
    e.crc    = exp_crc;
    e.err    = chk && (exp_crc != f);
    sb.push_back(e);
    acc_q.push_back(acc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  logic prev_v = 1'b0;
  int   mon_a;
  exp_t mon_e;
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (acc_q.size() == 0) fail_now("unexpected_out_valid");
      else begin
        mon_a = acc_q.pop_front();
        check("latency", cyc - mon_a, NSTEP);
      end
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) fail_now("unexpected_output");
      else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_crc", out_crc, mon_e.crc);
`ifdef CRC_CHECK_EN
        check("crc_err", crc_err, mon_e.err);
`endif
        hs_cyc = cyc + 1;
      end
    end
    prev_v = out_valid;
  end

  initial begin
    int a, a2, a3, n;
    logic [DW-1:0] hold_exp;
    logic saw_v;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_crc", out_crc, 16'hFFFF);
    rst = 1'b1;

    // One bit per cycle instance
    @(negedge clk);
    in_data   = {V1, 16'h0000};
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bpc1_latency", cyc - a, 72);
    check("bpc1_crc", out_crc1, C1);
    check("bpc1_data", out_data1, {V1, C1});
    @(posedge clk);
    #1;

    // Back-to-back generate packets
    send(V1, 16'h0000, 1'b0, C1, a);
    send(72'h0, 16'hABCD, 1'b0, ref_crc(72'h0), a2);
    check("b2b_interval_1", a2 - a, NSTEP + 2);
    send({PW{1'b1}}, 16'h1234, 1'b0, ref_crc({PW{1'b1}}), a3);
    check("b2b_interval_2", a3 - a2, NSTEP + 2);
    wait_drain();

    // Downstream stall in HOLD
    out_ready = 1'b0;
    send(72'h800000000000000001, 16'h0000, 1'b0, ref_crc(72'h800000000000000001), a);
    hold_exp = {72'h800000000000000001, ref_crc(72'h800000000000000001)};
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_data", out_data, hold_exp);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      check("hold_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(V1, 16'h0000, 1'b0, C1, a);
    check("accept_after_hs", a, hs_cyc + 1);
    wait_drain();

    // Reset in the middle of CALC
    send(V1, 16'h0000, 1'b0, C1, a);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_crc", out_crc, 16'hFFFF);
    sb.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_v = 1'b0;
    for (int i = 0; i < NSTEP + 4; i++) begin
      @(negedge clk);
      if (out_valid) saw_v = 1'b1;
    end
    check("no_valid_after_rst", saw_v, 1'b0);
    send(V1, 16'h0000, 1'b0, C1, a);
    wait_drain();

`ifdef CRC_CHECK_EN
    send(V1, C1, 1'b1, C1, a);
    send(V1, 16'h29B0, 1'b1, C1, a);
    send(V1, 16'h29B0, 1'b0, C1, a);
    wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
